// File: rtl/ratio_counter_spi.sv
// Counts MAJOR_CLOCK cycles over a programmable number of MINOR_CLOCK periods.
// Results are double-buffered and read out over an SPI slave in the MAJOR_CLOCK domain.
module ratio_counter_spi #(
    parameter bit          CPOL            = 1'b1,
    parameter int unsigned DOWNCOUNT_WIDTH = 16,
    parameter int unsigned UPCOUNT_WIDTH   = 40
) (
    input  logic MAJOR_CLOCK,
    input  logic RESET_N,
    input  logic MINOR_CLOCK,
    input  logic SCK,
    input  logic SS,
    input  logic SDI,
    output logic SDO,
    output logic FPGA_INT
);

    localparam int unsigned W   = 8 + DOWNCOUNT_WIDTH + UPCOUNT_WIDTH;
    localparam int unsigned BCW = $clog2(W + 2);
    localparam logic [BCW-1:0] BITS_FULL = BCW'(W);
    localparam logic [BCW-1:0] BITS_SAT  = BCW'(W + 1);
    localparam logic [UPCOUNT_WIDTH-1:0]   CNT_MAX = '1;
    localparam logic [DOWNCOUNT_WIDTH-1:0] REM_ONE = DOWNCOUNT_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StArm, StCount} state_e;

    logic [2:0] minor_sync_q, sck_sync_q, ss_sync_q;
    logic [1:0] sdi_sync_q;

    logic [W-1:0]               shift_q;
    logic [BCW-1:0]             bit_cnt_q;
    logic                       sdo_q;
    logic [DOWNCOUNT_WIDTH-1:0] gate_len_q, remaining_q;
    logic [UPCOUNT_WIDTH-1:0]   cnt_q, result_q;
    logic                       cnt_ovf_q, cont_q, valid_q, ovf_q, ferr_q;
    logic [2:0]                 seq_q;
    state_e                     state_q;

    logic                       minor_rise, spi_sample, spi_latch, ss_fall, ss_rise;
    logic                       commit, start_ok, end_gate, cnt_sat;
    logic [DOWNCOUNT_WIDTH-1:0] rx_gate;
    logic [UPCOUNT_WIDTH-1:0]   cnt_next;
    logic [7:0]                 status;

    // SS synchronizer resets to idle-high so reset release never looks like a frame edge.
    always_ff @(posedge MAJOR_CLOCK) begin
        if (!RESET_N) begin
            minor_sync_q <= '0;
            sck_sync_q   <= '0;
            ss_sync_q    <= '1;
            sdi_sync_q   <= '0;
        end else begin
            minor_sync_q <= {minor_sync_q[1:0], MINOR_CLOCK};
            sck_sync_q   <= {sck_sync_q[1:0], SCK ^ CPOL};
            ss_sync_q    <= {ss_sync_q[1:0], SS};
            sdi_sync_q   <= {sdi_sync_q[0], SDI};
        end
    end

    assign minor_rise = minor_sync_q[1] & ~minor_sync_q[2];
    assign spi_sample = sck_sync_q[1] & ~sck_sync_q[2] & ~ss_sync_q[1];
    assign spi_latch  = ~sck_sync_q[1] & sck_sync_q[2] & ~ss_sync_q[1];
    assign ss_fall    = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise    = ss_sync_q[1] & ~ss_sync_q[2];

    assign rx_gate  = shift_q[W-9 -: DOWNCOUNT_WIDTH];
    assign commit   = ss_rise && (bit_cnt_q == BITS_FULL);
    assign start_ok = commit && shift_q[W-1] && (rx_gate != '0);
    assign end_gate = (state_q == StCount) && minor_rise && (remaining_q <= REM_ONE);
    assign cnt_sat  = (cnt_q == CNT_MAX);
    assign cnt_next = cnt_sat ? CNT_MAX : cnt_q + UPCOUNT_WIDTH'(1);
    assign status   = {state_q != StIdle, cont_q, valid_q, ovf_q, ferr_q, seq_q};

    always_ff @(posedge MAJOR_CLOCK) begin
        if (!RESET_N) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sdo_q       <= 1'b0;
            gate_len_q  <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            cnt_ovf_q   <= 1'b0;
            cont_q      <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
            seq_q       <= '0;
            state_q     <= StIdle;
        end else begin
            if (ss_fall) begin
                shift_q   <= {status, gate_len_q, result_q};
                bit_cnt_q <= '0;
                sdo_q     <= status[7];
            end else begin
                if (spi_sample) begin
                    shift_q <= {shift_q[W-2:0], sdi_sync_q[1]};
                    if (bit_cnt_q != BITS_SAT) begin
                        bit_cnt_q <= bit_cnt_q + BCW'(1);
                    end
                end
                if (spi_latch) begin
                    sdo_q <= shift_q[W-1];
                end
            end

            if (ss_rise) begin
                if (commit) begin
                    gate_len_q <= rx_gate;
                    cont_q     <= shift_q[W-2];
                    if (shift_q[W-3]) begin
                        valid_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                    if (shift_q[W-1] && (rx_gate == '0)) begin
                        ferr_q <= 1'b1;
                    end
                end else begin
                    ferr_q <= 1'b1;
                end
            end

            // End-of-gate assignments follow the commit so a fresh result beats CLR.
            case (state_q)
                StIdle: ;
                StArm: begin
                    if (minor_rise) begin
                        cnt_q       <= '0;
                        remaining_q <= gate_len_q;
                        cnt_ovf_q   <= 1'b0;
                        state_q     <= StCount;
                    end
                end
                StCount: begin
                    cnt_q <= cnt_next;
                    if (cnt_sat) begin
                        cnt_ovf_q <= 1'b1;
                    end
                    if (end_gate) begin
                        result_q <= cnt_next;
                        ovf_q    <= cnt_ovf_q | cnt_sat;
                        valid_q  <= 1'b1;
                        seq_q    <= seq_q + 3'd1;
                        if (cont_q) begin
                            cnt_q       <= '0;
                            remaining_q <= gate_len_q;
                            cnt_ovf_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (minor_rise) begin
                        remaining_q <= remaining_q - REM_ONE;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (start_ok) begin
                state_q <= StArm;
            end
        end
    end

    assign SDO      = SS ? 1'bz : sdo_q;
    assign FPGA_INT = valid_q;

endmodule

// File: tb/tb_ratio_counter_spi.sv
// Randomized bench for ratio_counter_spi: MINOR edges are generated with recorded timestamps and
// expected results come from the time between the arming edge and the final edge.
module tb_ratio_counter_spi;

    localparam bit          CPOL = 1'b1;
    localparam int unsigned DW   = 16;
    localparam int unsigned UW   = 12;
    localparam int unsigned W    = 8 + DW + UW;
    localparam int          H    = 8;
    localparam longint      MAXR = 4095;

    logic MAJOR_CLOCK = 1'b0;
    logic RESET_N     = 1'b0;
    logic MINOR_CLOCK = 1'b0;
    logic SCK         = CPOL;
    logic SS          = 1'b1;
    logic SDI         = 1'b0;
    wire  SDO;
    wire  FPGA_INT;

    int     checks = 0;
    int     errors = 0;
    int     exp_seq = 0;
    longint edges[$];
    logic [W-1:0] rx;

    ratio_counter_spi #(
        .CPOL(CPOL),
        .DOWNCOUNT_WIDTH(DW),
        .UPCOUNT_WIDTH(UW)
    ) dut (
        .MAJOR_CLOCK(MAJOR_CLOCK),
        .RESET_N(RESET_N),
        .MINOR_CLOCK(MINOR_CLOCK),
        .SCK(SCK),
        .SS(SS),
        .SDI(SDI),
        .SDO(SDO),
        .FPGA_INT(FPGA_INT)
    );

    always #5 MAJOR_CLOCK = ~MAJOR_CLOCK;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge MAJOR_CLOCK);
        #1;
    endtask

    task automatic spi_frame(input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rxd);
        rxd = '0;
        SS  = 1'b0;
        cyc(H);
        for (int i = 0; i < nbits; i++) begin
            SDI = tx[W-1-i];
            cyc(H);
            SCK = ~CPOL;
            rxd = {rxd[W-2:0], SDO};
            cyc(H);
            SCK = CPOL;
        end
        cyc(H);
        SS = 1'b1;
        cyc(H);
    endtask

    // Rising MINOR edges exactly p MAJOR periods apart, off the MAJOR edge.
    task automatic pulse_minor(input int n, input int p);
        @(posedge MAJOR_CLOCK);
        #2;
        for (int i = 0; i < n; i++) begin
            MINOR_CLOCK = 1'b1;
            edges.push_back($time);
            #(p * 5);
            MINOR_CLOCK = 1'b0;
            #(p * 5);
        end
    endtask

    function automatic longint span(input int a, input int b);
        return (edges[b] - edges[a]) / 10;
    endfunction

    function automatic logic [UW-1:0] sat_res(input longint d);
        return (d > MAXR) ? UW'(MAXR) : UW'(d);
    endfunction

    function automatic logic [7:0] st(input bit busy, input bit cont, input bit valid,
                                      input bit ovf, input bit ferr, input int seq);
        return {busy, cont, valid, ovf, ferr, 3'(seq % 8)};
    endfunction

    task automatic readout(input string tag, input logic [7:0] ctrl, input logic [DW-1:0] gate,
                           input logic [7:0] exp_st, input logic [UW-1:0] exp_res,
                           input logic [DW-1:0] exp_gate);
        logic [W-1:0] r;
        spi_frame({ctrl, gate, {UW{1'b0}}}, W, r);
        check_eq({tag, ".status"}, r[W-1 -: 8], exp_st);
        check_eq({tag, ".gate"}, r[W-9 -: DW], exp_gate);
        check_eq({tag, ".result"}, r[UW-1:0], exp_res);
    endtask

    task automatic wait_int(input string tag, input int bound);
        int n = 0;
        while (!FPGA_INT && n < bound) begin
            cyc(1);
            n++;
        end
        check_eq(tag, FPGA_INT, 1);
    endtask

    initial begin
        int g, p;
        longint d, d_old;
        logic [UW-1:0] last_res;

        RESET_N = 1'b0;
        cyc(4);
        RESET_N = 1'b1;
        cyc(4);
        check_eq("reset.int", FPGA_INT, 0);
        readout("reset", 8'h00, 16'd0, st(0, 0, 0, 0, 0, 0), 12'd0, 16'd0);

        // Single shot: fixed 4 x 10 first, then random gates and ratios.
        for (int it = 0; it < 4; it++) begin
            g = (it == 0) ? 4 : int'($urandom_range(1, 6));
            p = (it == 0) ? 10 : int'($urandom_range(6, 14));
            spi_frame({8'h80, 16'(g), {UW{1'b0}}}, W, rx);
            edges.delete();
            pulse_minor(g + 2, p);
            wait_int("single.int", 50);
            exp_seq++;
            readout("single", 8'h00, 16'(g), st(0, 0, 1, 0, 0, exp_seq), sat_res(span(0, g)),
                    16'(g));
        end

        // Continuous: three back-to-back gates.
        spi_frame({8'hC0, 16'd4, {UW{1'b0}}}, W, rx);
        edges.delete();
        pulse_minor(13, 10);
        exp_seq += 3;
        d_old = span(8, 12);
        check_eq("cont.gap_free", span(0, 4) + span(4, 8) + span(8, 12), span(0, 12));
        readout("cont", 8'h40, 16'd4, st(1, 1, 1, 0, 0, exp_seq), sat_res(d_old), 16'd4);

        // A frame spanning an end of gate shows the snapshot from SS fall.
        fork
            readout("span_old", 8'h40, 16'd4, st(1, 1, 1, 0, 0, exp_seq), sat_res(d_old), 16'd4);
            begin
                cyc(3 * H);
                pulse_minor(4, 10);
            end
        join
        exp_seq++;
        readout("span_new", 8'h00, 16'd4, st(1, 1, 1, 0, 0, exp_seq), sat_res(span(12, 16)),
                16'd4);
        pulse_minor(4, 10);
        exp_seq++;
        readout("cont_stop", 8'h00, 16'd4, st(0, 0, 1, 0, 0, exp_seq), sat_res(span(16, 20)),
                16'd4);

        // Overflow, then CLR.
        spi_frame({8'h80, 16'd420, {UW{1'b0}}}, W, rx);
        edges.delete();
        pulse_minor(421, 10);
        exp_seq++;
        d = span(0, 420);
        readout("ovf", 8'h00, 16'd420, st(0, 0, 1, d > MAXR, 0, exp_seq), sat_res(d), 16'd420);
        readout("clr", 8'h20, 16'd420, st(0, 0, 1, d > MAXR, 0, exp_seq), sat_res(d), 16'd420);
        check_eq("clr.int", FPGA_INT, 0);

        // Result exactly at the top of the counter range is not an overflow.
        spi_frame({8'h80, 16'd315, {UW{1'b0}}}, W, rx);
        edges.delete();
        pulse_minor(316, 13);
        exp_seq++;
        d = span(0, 315);
        last_res = sat_res(d);
        readout("edge_max", 8'h20, 16'd315, st(0, 0, 1, d > MAXR, 0, exp_seq), last_res, 16'd315);

        // Short frame: no commit, FRAME_ERR set, no measurement.
        spi_frame({8'h80, 16'd4, {UW{1'b0}}}, 20, rx);
        edges.delete();
        pulse_minor(6, 10);
        check_eq("bad.int", FPGA_INT, 0);
        readout("bad", 8'h00, 16'd315, st(0, 0, 0, 0, 1, exp_seq), last_res, 16'd315);

        // CLR plus START with gate 0: error flag reasserted, FSM stays idle.
        spi_frame({8'hA0, 16'd0, {UW{1'b0}}}, W, rx);
        pulse_minor(6, 10);
        check_eq("gate0.int", FPGA_INT, 0);
        readout("gate0", 8'h00, 16'd0, st(0, 0, 0, 0, 1, exp_seq), last_res, 16'd0);

        // Reset mid-count and mid-frame.
        spi_frame({8'hC0, 16'd4, {UW{1'b0}}}, W, rx);
        edges.delete();
        fork
            pulse_minor(10, 10);
            begin
                cyc(70);
                SS = 1'b0;
                cyc(H);
                for (int i = 0; i < 3; i++) begin
                    SDI = 1'b1;
                    cyc(H);
                    SCK = ~CPOL;
                    cyc(H);
                    SCK = CPOL;
                end
                check_eq("pre_rst.int", FPGA_INT, 1);
                RESET_N = 1'b0;
                SS      = 1'b1;
                cyc(1);
                RESET_N = 1'b1;
                check_eq("rst.int", FPGA_INT, 0);
            end
        join
        exp_seq = 0;
        cyc(4);
        readout("post_rst", 8'h00, 16'd0, st(0, 0, 0, 0, 0, exp_seq), 12'd0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
